// File: rtl/muldiv_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit: op codes, FSM
// state encoding, op-field width and small op-classification helpers.
// Ops 6/7 (MADD/MADDU) only take effect when MULDIV_MADD_EN is defined.
package muldiv_pkg;

   localparam int OpWidth = 3;

   typedef enum logic [OpWidth-1:0] {
      OP_MULT  = 3'd0,
      OP_MULTU = 3'd1,
      OP_DIV   = 3'd2,
      OP_DIVU  = 3'd3,
      OP_MTHI  = 3'd4,
      OP_MTLO  = 3'd5,
      OP_MADD  = 3'd6,
      OP_MADDU = 3'd7
   } opCode_t;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_MUL  = 2'd1,
      S_DIV  = 2'd2,
      S_FIX  = 2'd3
   } state_t;

   // Multiplier sign mode for a latched multiply-family op.
   function automatic logic isUnsignedMul(input opCode_t opIn);
      return (opIn == OP_MULTU) || (opIn == OP_MADDU);
   endfunction

   // Divide-family ops.
   function automatic logic isDivOp(input opCode_t opIn);
      return (opIn == OP_DIV) || (opIn == OP_DIVU);
   endfunction

endpackage

// File: rtl/divider_step.sv
// One combinational restoring-division iteration: shift the partial
// remainder left, bring in the next dividend bit, and subtract the divisor
// when it fits. Kept separate so the divide datapath can be tested alone.
module divider_step #(
   parameter int BitWidth = 32
) (
   input  logic [BitWidth-1:0] i_remainder,
   input  logic [BitWidth-1:0] i_divisor,
   input  logic                i_dividendBit,
   output logic [BitWidth-1:0] o_remainder,
   output logic                o_quotBit
);

   logic [BitWidth:0] w_shifted;
   logic [BitWidth:0] w_diff;

   // The shifted remainder needs one extra bit because it can reach
   // 2*divisor-1, which may exceed BitWidth bits for large divisors.
   always_comb begin
      w_shifted   = {i_remainder, i_dividendBit};
      w_diff      = w_shifted - {1'b0, i_divisor};
      o_quotBit   = (w_shifted >= {1'b0, i_divisor});
      o_remainder = BitWidth'(o_quotBit ? w_diff : w_shifted);
   end

endmodule

// File: rtl/multiplier.sv
// Combinational BitWidth x BitWidth multiplier with signed/unsigned mode.
// Produces the full 2*BitWidth product; output is forced to zero when not
// enabled so downstream logic never sees a toggling product while idle.
module multiplier #(
   parameter int BitWidth = 32
) (
   input  logic                  i_enable,
   input  logic                  i_isUnsigned,
   input  logic [BitWidth-1:0]   i_a,
   input  logic [BitWidth-1:0]   i_b,
   output logic [2*BitWidth-1:0] o_product
);

   logic                         w_aSign;
   logic                         w_bSign;
   logic signed [2*BitWidth-1:0] w_aExt;
   logic signed [2*BitWidth-1:0] w_bExt;
   logic signed [2*BitWidth-1:0] w_full;

   // Extend both operands to the product width; the low 2*BitWidth bits of
   // the extended product are correct for both signed and unsigned modes.
   always_comb begin
      w_aSign = ~i_isUnsigned & i_a[BitWidth-1];
      w_bSign = ~i_isUnsigned & i_b[BitWidth-1];
      w_aExt  = {{BitWidth{w_aSign}}, i_a};
      w_bExt  = {{BitWidth{w_bSign}}, i_b};
      w_full  = w_aExt * w_bExt;
      o_product = i_enable ? w_full : '0;
   end

endmodule

// File: rtl/muldiv_controller.sv
// HI/LO arithmetic sequencer for the MIPS core. Runs the combinational
// multiplier as a multicycle path fed from latched operands, runs an
// iterative restoring divider one bit per cycle, owns HI/LO, and raises
// busy so the pipeline stalls HI/LO consumers until the result commits.
// Optional feature macro: MULDIV_MADD_EN (ops 6/7 become MADD/MADDU, which
// accumulate the product into {hi,lo}); without it ops 6/7 are ignored.
module muldiv_controller
   import muldiv_pkg::*;
#(
   parameter int BitWidth  = 32,
   parameter int MulCycles = 2
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                start,
   input  logic [OpWidth-1:0]  op,
   input  logic [BitWidth-1:0] operandA,
   input  logic [BitWidth-1:0] operandB,
   output logic                busy,
   output logic                done,
   output logic [BitWidth-1:0] hi,
   output logic [BitWidth-1:0] lo
);

   localparam int CntMax = (BitWidth > MulCycles) ? (BitWidth - 1) : (MulCycles - 1);
   localparam int CntW   = (CntMax < 1) ? 1 : $clog2(CntMax + 1);

   state_t                r_state;
   logic [CntW-1:0]       r_count;
   logic [BitWidth-1:0]   r_opA;
   logic [BitWidth-1:0]   r_opB;
   opCode_t               r_op;
   logic [BitWidth-1:0]   r_rem;
   logic [BitWidth-1:0]   r_divQ;
   logic [BitWidth-1:0]   r_divisor;
   logic                  r_negQuot;
   logic                  r_negRem;
   logic                  r_divZero;
   logic [BitWidth-1:0]   r_hi;
   logic [BitWidth-1:0]   r_lo;
   logic                  r_done;

   opCode_t               w_opCode;
   logic                  w_isMul;
   logic                  w_isDiv;
   logic                  w_signedDiv;
   logic                  w_aNeg;
   logic                  w_bNeg;
   logic [BitWidth-1:0]   w_aMag;
   logic [BitWidth-1:0]   w_bMag;
   logic                  w_mulEnable;
   logic                  w_mulUnsigned;
   logic [2*BitWidth-1:0] w_product;
   logic [2*BitWidth-1:0] w_mulResult;
   logic [BitWidth-1:0]   w_stepRem;
   logic                  w_qBit;
   logic [BitWidth-1:0]   w_quotFixed;
   logic [BitWidth-1:0]   w_remFixed;

   function automatic logic [BitWidth-1:0] twosNeg(input logic [BitWidth-1:0] v);
      return ~v + BitWidth'(1);
   endfunction

   assign w_opCode = opCode_t'(op);

   // Classify the incoming op; reserved codes fall through as neither
   // multiply nor divide and are therefore ignored by the FSM.
   always_comb begin
      w_isMul = 1'b0;
      w_isDiv = isDivOp(w_opCode);
      case (w_opCode)
         OP_MULT, OP_MULTU: w_isMul = 1'b1;
`ifdef MULDIV_MADD_EN
         OP_MADD, OP_MADDU: w_isMul = 1'b1;
`endif
         default:           w_isMul = 1'b0;
      endcase
   end

   // Signed divides run on magnitudes; the signs are restored in FIX.
   always_comb begin
      w_signedDiv = (w_opCode == OP_DIV);
      w_aNeg      = w_signedDiv & operandA[BitWidth-1];
      w_bNeg      = w_signedDiv & operandB[BitWidth-1];
      w_aMag      = w_aNeg ? twosNeg(operandA) : operandA;
      w_bMag      = w_bNeg ? twosNeg(operandB) : operandB;
   end

   // The multiplier only ever sees the latched operands, so its inputs are
   // stable for the whole multicycle settling window.
   assign w_mulEnable   = (r_state == S_MUL);
   assign w_mulUnsigned = isUnsignedMul(r_op);

   multiplier #(
      .BitWidth (BitWidth)
   ) u_multiplier (
      .i_enable     (w_mulEnable),
      .i_isUnsigned (w_mulUnsigned),
      .i_a          (r_opA),
      .i_b          (r_opB),
      .o_product    (w_product)
   );

`ifdef MULDIV_MADD_EN
   logic w_accumulate;

   // MADD/MADDU add the product into the current {hi,lo}, wrapping at
   // 2*BitWidth bits; the add sits on the capture edge so latency is kept.
   always_comb begin
      w_accumulate = (r_op == OP_MADD) || (r_op == OP_MADDU);
      w_mulResult  = w_accumulate ? ({r_hi, r_lo} + w_product) : w_product;
   end
`else
   assign w_mulResult = w_product;
`endif

   divider_step #(
      .BitWidth (BitWidth)
   ) u_divider_step (
      .i_remainder   (r_rem),
      .i_divisor     (r_divisor),
      .i_dividendBit (r_divQ[BitWidth-1]),
      .o_remainder   (w_stepRem),
      .o_quotBit     (w_qBit)
   );

   // Sign correction: quotient negated when operand signs differ, remainder
   // follows the dividend's sign.
   always_comb begin
      w_quotFixed = r_negQuot ? twosNeg(r_divQ) : r_divQ;
      w_remFixed  = r_negRem  ? twosNeg(r_rem)  : r_rem;
   end

   // Main sequencer: accepts ops in IDLE, counts the multiply settling
   // window, steps the divider once per cycle, and commits HI/LO.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state   <= S_IDLE;
         r_count   <= '0;
         r_opA     <= '0;
         r_opB     <= '0;
         r_op      <= OP_MULT;
         r_rem     <= '0;
         r_divQ    <= '0;
         r_divisor <= '0;
         r_negQuot <= 1'b0;
         r_negRem  <= 1'b0;
         r_divZero <= 1'b0;
         r_hi      <= '0;
         r_lo      <= '0;
         r_done    <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_opA <= operandA;
                  r_opB <= operandB;
                  r_op  <= w_opCode;
                  if (w_opCode == OP_MTHI) begin
                     r_hi <= operandA;
                  end else if (w_opCode == OP_MTLO) begin
                     r_lo <= operandA;
                  end else if (w_isMul) begin
                     r_state <= S_MUL;
                     r_count <= CntW'(MulCycles - 1);
                  end else if (w_isDiv) begin
                     r_state   <= S_DIV;
                     r_count   <= CntW'(BitWidth - 1);
                     r_rem     <= '0;
                     r_divQ    <= w_aMag;
                     r_divisor <= w_bMag;
                     r_negQuot <= w_aNeg ^ w_bNeg;
                     r_negRem  <= w_aNeg;
                     r_divZero <= (operandB == '0);
                  end
               end
            end
            S_MUL: begin
               if (r_count == '0) begin
                  {r_hi, r_lo} <= w_mulResult;
                  r_done       <= 1'b1;
                  r_state      <= S_IDLE;
               end else begin
                  r_count <= r_count - CntW'(1);
               end
            end
            S_DIV: begin
               r_rem  <= w_stepRem;
               r_divQ <= {r_divQ[BitWidth-2:0], w_qBit};
               if (r_count == '0) begin
                  r_state <= S_FIX;
               end else begin
                  r_count <= r_count - CntW'(1);
               end
            end
            S_FIX: begin
               if (r_divZero) begin
                  r_lo <= '1;
                  r_hi <= r_opA;
               end else begin
                  r_lo <= w_quotFixed;
                  r_hi <= w_remFixed;
               end
               r_done  <= 1'b1;
               r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign busy = (r_state != S_IDLE);
   assign done = r_done;
   assign hi   = r_hi;
   assign lo   = r_lo;

endmodule
